// File: rtl/ex_pkg.sv
// ex_pkg -- shared definitions for the EX-stage mul/div slice.
//   op_e       : 4-bit operation code presented on the EX stage 'op' port
//   FWD_*      : operand forward-select encodings (3 also selects the regfile)
//   state_e    : state encoding of the sequential mul/div unit
//   uses_seq() : true for ops that start the sequential unit
// Optional feature: define EX_MULDIV_DIV_EN to build DIV/DIVU into the
// sequential unit; without it only MULT/MULTU start the unit.
package ex_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'd0,
    OP_OR    = 4'd1,
    OP_ADD   = 4'd2,
    OP_SUB   = 4'd3,
    OP_SLT   = 4'd4,
    OP_XOR   = 4'd5,
    OP_NOR   = 4'd6,
    OP_SLL   = 4'd7,
    OP_MULT  = 4'd8,
    OP_MULTU = 4'd9,
    OP_DIV   = 4'd10,
    OP_DIVU  = 4'd11,
    OP_MFHI  = 4'd12,
    OP_MFLO  = 4'd13
  } op_e;

  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_WB    = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic uses_seq(input op_e op);
`ifdef EX_MULDIV_DIV_EN
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
`else
    return (op == OP_MULT) || (op == OP_MULTU);
`endif
  endfunction

endpackage

// File: rtl/ex_muldiv_seq.sv
// ex_muldiv_seq -- radix-2 sequential multiplier/divider plus HI/LO registers.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : begin an operation with op_a/op_b (ignored unless idle/done)
//   is_div, is_signed   : operation kind latched on start
//   flush               : abandon a running operation, HI/LO untouched
//   op_a, op_b          : operands (multiplicand/multiplier or dividend/divisor)
//   busy                : high for exactly DATA_W cycles after start
//   hi, lo              : HI/LO result registers
// Optional feature: EX_MULDIV_DIV_EN builds the restoring divider; without it
// divide requests are ignored and no divider logic exists.
module ex_muldiv_seq
  import ex_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_div,
  input  logic              is_signed,
  input  logic              flush,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              busy,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  state_e              state_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [DATA_W-1:0]   acc_hi_reg, acc_lo_reg, opb_reg, hi_reg, lo_reg;
  logic                neg_q_reg, busy_reg;

  logic                start_ok, a_neg, b_neg, div0, last_step;
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic [DATA_W-1:0]   step_hi, step_lo, fin_hi, fin_lo;
  logic [DATA_W:0]     mul_sum;
  logic [DATA_W-1:0]   mul_hi, mul_lo;
  logic [2*DATA_W-1:0] prod;

`ifdef EX_MULDIV_DIV_EN
  logic                is_div_reg, neg_r_reg;
  logic [DATA_W:0]     rem_sh, rem_diff;
  logic [DATA_W-1:0]   div_hi, div_lo;

  assign start_ok = start;
  assign div0     = is_div & (op_b == '0);
`else
  assign start_ok = start & ~is_div;
  assign div0     = 1'b0;
`endif

  // Signed ops run on magnitudes and fix the sign at the end. A zero divisor
  // skips the magnitude step so the unsigned datapath naturally yields
  // quotient = all ones and remainder = the raw dividend.
  assign a_neg = is_signed & op_a[DATA_W-1] & ~div0;
  assign b_neg = is_signed & op_b[DATA_W-1];
  assign a_mag = a_neg ? -op_a : op_a;
  assign b_mag = b_neg ? -op_b : op_b;

  // Shift-add multiply: acc_lo holds the multiplier and fills with product bits.
  assign mul_sum = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, opb_reg} : '0);
  assign mul_hi  = mul_sum[DATA_W:1];
  assign mul_lo  = {mul_sum[0], acc_lo_reg[DATA_W-1:1]};
  assign prod    = neg_q_reg ? -{mul_hi, mul_lo} : {mul_hi, mul_lo};

`ifdef EX_MULDIV_DIV_EN
  // Restoring divide: acc_hi is the partial remainder, acc_lo shifts the
  // dividend out and the quotient in. rem_diff[DATA_W] is the borrow.
  assign rem_sh   = {acc_hi_reg, acc_lo_reg[DATA_W-1]};
  assign rem_diff = rem_sh - {1'b0, opb_reg};
  assign div_hi   = rem_diff[DATA_W] ? rem_sh[DATA_W-1:0] : rem_diff[DATA_W-1:0];
  assign div_lo   = {acc_lo_reg[DATA_W-2:0], ~rem_diff[DATA_W]};

  always_comb begin
    if (is_div_reg) begin
      step_hi = div_hi;
      step_lo = div_lo;
      fin_hi  = neg_r_reg ? -div_hi : div_hi;
      fin_lo  = neg_q_reg ? -div_lo : div_lo;
    end else begin
      step_hi = mul_hi;
      step_lo = mul_lo;
      fin_hi  = prod[2*DATA_W-1:DATA_W];
      fin_lo  = prod[DATA_W-1:0];
    end
  end
`else
  always_comb begin
    step_hi = mul_hi;
    step_lo = mul_lo;
    fin_hi  = prod[2*DATA_W-1:DATA_W];
    fin_lo  = prod[DATA_W-1:0];
  end
`endif

  assign last_step = (cnt_reg == CNT_W'(DATA_W - 1));

  // RUN performs one iteration per cycle; the final iteration writes HI/LO
  // directly so busy drops right after the DATA_W-th busy cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
      acc_hi_reg <= '0;
      acc_lo_reg <= '0;
      opb_reg    <= '0;
      neg_q_reg  <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
`ifdef EX_MULDIV_DIV_EN
      is_div_reg <= 1'b0;
      neg_r_reg  <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (flush) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
          end else begin
            acc_hi_reg <= step_hi;
            acc_lo_reg <= step_lo;
            cnt_reg    <= cnt_reg + CNT_W'(1);
            if (last_step) begin
              state_reg <= ST_DONE;
              busy_reg  <= 1'b0;
              hi_reg    <= fin_hi;
              lo_reg    <= fin_lo;
            end
          end
        end
        default: begin
          // IDLE and DONE both accept a new operation.
          cnt_reg <= '0;
          if (start_ok) begin
            state_reg  <= ST_RUN;
            busy_reg   <= 1'b1;
            acc_hi_reg <= '0;
            acc_lo_reg <= a_mag;
            opb_reg    <= b_mag;
            neg_q_reg  <= a_neg ^ b_neg;
`ifdef EX_MULDIV_DIV_EN
            is_div_reg <= is_div;
            neg_r_reg  <= a_neg;
`endif
          end else begin
            state_reg <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: rtl/ex_muldiv_stage.sv
// ex_muldiv_stage -- EX stage: operand forwarding, single-cycle ALU, and the
// sequential multiply/divide unit with HI/LO.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   in_valid / in_ready     : issue handshake (accept when both high)
//   flush                   : kill in-flight op; beats a simultaneous in_valid
//   op                      : ex_pkg::op_e operation code
//   rs_val, rt_val          : register-file operands
//   imm, use_imm            : immediate operand and select for operand B
//   fwd_a, fwd_b            : forward selects (0/3 regfile, 1 exmem, 2 wb)
//   fwd_exmem, fwd_wb       : forwarded values
//   out_valid, out_wr       : one-cycle result pulse and register-write enable
//   result, store_data      : registered result and forwarded rt
//   busy, stall             : mul/div running; in_valid & ~in_ready
// Optional feature: EX_MULDIV_DIV_EN enables the sequential divider. Without
// it DIV/DIVU retire in one cycle with out_wr=0 and do not touch HI/LO.
module ex_muldiv_stage
  import ex_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic [DATA_W-1:0] imm,
  input  logic              use_imm,
  input  logic [1:0]        fwd_a,
  input  logic [1:0]        fwd_b,
  input  logic [DATA_W-1:0] fwd_exmem,
  input  logic [DATA_W-1:0] fwd_wb,
  output logic              out_valid,
  output logic              out_wr,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] store_data,
  output logic              busy,
  output logic              stall
);

  op_e               op_q;
  logic [DATA_W-1:0] a_sel, rt_sel, b_sel, alu_res, hi, lo;
  logic [31:0]       shamt;
  logic              alu_wr, accept, seq_busy, seq_start, seq_is_div, seq_signed;

  logic              out_valid_reg, out_wr_reg;
  logic [DATA_W-1:0] result_reg, store_data_reg;

  assign op_q = op_e'(op);

  always_comb begin
    case (fwd_a)
      FWD_EXMEM: a_sel = fwd_exmem;
      FWD_WB:    a_sel = fwd_wb;
      default:   a_sel = rs_val;
    endcase
    case (fwd_b)
      FWD_EXMEM: rt_sel = fwd_exmem;
      FWD_WB:    rt_sel = fwd_wb;
      default:   rt_sel = rt_val;
    endcase
  end

  assign b_sel = use_imm ? imm : rt_sel;
  assign shamt = 32'(a_sel[4:0]) % 32'(DATA_W);

  // Mul/div ops (and undefined codes) retire with result 0 and no write.
  always_comb begin
    alu_res = '0;
    alu_wr  = 1'b1;
    case (op_q)
      OP_AND:  alu_res = a_sel & b_sel;
      OP_OR:   alu_res = a_sel | b_sel;
      OP_ADD:  alu_res = a_sel + b_sel;
      OP_SUB:  alu_res = a_sel - b_sel;
      OP_SLT:  alu_res = DATA_W'($signed(a_sel) < $signed(b_sel));
      OP_XOR:  alu_res = a_sel ^ b_sel;
      OP_NOR:  alu_res = ~(a_sel | b_sel);
      OP_SLL:  alu_res = b_sel << shamt;
      OP_MFHI: alu_res = hi;
      OP_MFLO: alu_res = lo;
      default: alu_wr  = 1'b0;
    endcase
  end

  assign in_ready   = ~seq_busy;
  assign stall      = in_valid & ~in_ready;
  assign accept     = in_valid & in_ready & ~flush;
  assign seq_start  = accept & uses_seq(op_q);
  assign seq_is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);
  assign seq_signed = (op_q == OP_MULT) || (op_q == OP_DIV);

  ex_muldiv_seq #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (seq_start),
    .is_div    (seq_is_div),
    .is_signed (seq_signed),
    .flush     (flush),
    .op_a      (a_sel),
    .op_b      (b_sel),
    .busy      (seq_busy),
    .hi        (hi),
    .lo        (lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg  <= 1'b0;
      out_wr_reg     <= 1'b0;
      result_reg     <= '0;
      store_data_reg <= '0;
    end else begin
      out_valid_reg <= accept;
      out_wr_reg    <= accept & alu_wr;
      if (accept) begin
        result_reg     <= alu_res;
        store_data_reg <= rt_sel;
      end
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_wr     = out_wr_reg;
  assign result     = result_reg;
  assign store_data = store_data_reg;
  assign busy       = seq_busy;

endmodule

// File: tb/tb_ex_muldiv_stage.sv
// tb_ex_muldiv_stage -- directed self-checking bench for ex_muldiv_stage.
// Divide vectors depend on EX_MULDIV_DIV_EN, matching the build of the DUT.
module tb_ex_muldiv_stage;
  import ex_pkg::*;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              in_valid = 1'b0, in_ready, flush = 1'b0, use_imm = 1'b0;
  logic [3:0]        op = 4'd0;
  logic [DATA_W-1:0] rs_val = '0, rt_val = '0, imm = '0, fwd_exmem = '0, fwd_wb = '0;
  logic [1:0]        fwd_a = 2'd0, fwd_b = 2'd0;
  logic              out_valid, out_wr, busy, stall;
  logic [DATA_W-1:0] result, store_data;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  ex_muldiv_stage #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .flush      (flush),
    .op         (op),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .imm        (imm),
    .use_imm    (use_imm),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b),
    .fwd_exmem  (fwd_exmem),
    .fwd_wb     (fwd_wb),
    .out_valid  (out_valid),
    .out_wr     (out_wr),
    .result     (result),
    .store_data (store_data),
    .busy       (busy),
    .stall      (stall)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one op for a single clock; outputs are sampled 1 ns after the edge.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic ui, input logic [31:0] im,
                       input logic [1:0] fa, input logic [1:0] fb, input logic fl);
    @(negedge clk);
    op = o; rs_val = a; rt_val = b; use_imm = ui; imm = im;
    fwd_a = fa; fwd_b = fb; flush = fl; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    $display("op=%0d rs=%h rt=%h flush=%0b -> valid=%0b wr=%0b result=%h busy=%0b",
             o, a, b, fl, out_valid, out_wr, result, busy);
  endtask

  task automatic alu_chk(input string tag, input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic ui, input logic [31:0] im,
                         input logic [1:0] fa, input logic [1:0] fb, input logic [31:0] exp);
    issue(o, a, b, ui, im, fa, fb, 1'b0);
    check(tag, result, exp);
    check({tag, "_wr"}, out_wr, 1'b1);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  int n;

  initial begin
    // Reset
    #1 rst_n = 1'b0;
    #2;
    check("rst_result", result, 0);
    check("rst_store",  store_data, 0);
    check("rst_valid",  out_valid, 0);
    check("rst_wr",     out_wr, 0);
    check("rst_busy",   busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // ALU ops
    fwd_exmem = 32'd100;
    fwd_wb    = 32'd5;
    issue(OP_ADD, 32'd5, 32'd7, 1'b0, 32'd0, 2'd1, 2'd0, 1'b0);
    check("add_fwd",   result, 107);
    check("add_wr",    out_wr, 1);
    check("add_valid", out_valid, 1);
    check("add_store", store_data, 7);
    @(posedge clk); #1;
    check("add_pulse", out_valid, 0);

    alu_chk("sub_wrap", OP_SUB, 32'd3, 32'd99, 1'b0, 0, 2'd0, 2'd2, 32'hFFFFFFFE);
    check("sub_store", store_data, 5);
    alu_chk("slt_imm", OP_SLT, 32'hFFFFFFFF, 32'h55, 1'b1, 32'd1, 2'd0, 2'd0, 32'd1);
    check("slt_store", store_data, 32'h55);
    alu_chk("slt_neg", OP_SLT, 32'd1, 32'hFFFFFFFF, 1'b0, 0, 2'd0, 2'd0, 32'd0);
    alu_chk("sll_31",  OP_SLL, 32'h3F, 32'd3, 1'b0, 0, 2'd0, 2'd0, 32'h80000000);
    alu_chk("nor",     OP_NOR, 32'hF0F0F0F0, 32'h0F0F0000, 1'b0, 0, 2'd0, 2'd3, 32'h00000F0F);
    alu_chk("and",     OP_AND, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 0, 2'd0, 2'd0, 32'h0F000F00);
    alu_chk("or",      OP_OR,  32'h12340000, 32'h00005678, 1'b0, 0, 2'd0, 2'd0, 32'h12345678);
    alu_chk("xor",     OP_XOR, 32'hAAAA5555, 32'hFFFF0000, 1'b0, 0, 2'd0, 2'd0, 32'h55555555);
    alu_chk("add_wrap",OP_ADD, 32'hFFFFFFFF, 32'd2, 1'b0, 0, 2'd0, 2'd0, 32'd1);

    // Signed multiply: -1 * 2
    issue(OP_MULT, 32'hFFFFFFFF, 32'd2, 1'b0, 0, 2'd0, 2'd0, 1'b0);
    check("mult_valid", out_valid, 1);
    check("mult_wr",    out_wr, 0);
    check("mult_res0",  result, 0);
    check("mult_busy",  busy, 1);
    check("mult_ready", in_ready, 0);
    wait_idle(n);
    check("mult_cycles", n, 32);
    alu_chk("mult_hi", OP_MFHI, 0, 0, 1'b0, 0, 2'd0, 2'd0, 32'hFFFFFFFF);
    alu_chk("mult_lo", OP_MFLO, 0, 0, 1'b0, 0, 2'd0, 2'd0, 32'hFFFFFFFE);

    // MFLO issued while busy stalls, then returns the new LO
    issue(OP_MULTU, 32'h80000001, 32'd4, 1'b0, 0, 2'd0, 2'd0, 1'b0);
    op = OP_MFLO; in_valid = 1'b1;
    check("stall_hi", stall, 1);
    n = 0;
    while (stall && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("stall_cycles", n, 32);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("stall_mflo_valid", out_valid, 1);
    check("stall_mflo", result, 32'd4);
    alu_chk("multu_hi", OP_MFHI, 0, 0, 1'b0, 0, 2'd0, 2'd0, 32'd2);

    // Flush at RUN cycle 10 of a MULTU
    issue(OP_MULTU, 32'h0000FFFF, 32'h0000FFFF, 1'b0, 0, 2'd0, 2'd0, 1'b0);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", busy, 0);
    @(posedge clk); #1;
    check("flush_ready", in_ready, 1);
    alu_chk("flush_hi", OP_MFHI, 0, 0, 1'b0, 0, 2'd0, 2'd0, 32'd2);
    alu_chk("flush_lo", OP_MFLO, 0, 0, 1'b0, 0, 2'd0, 2'd0, 32'd4);

    // Flush in the acceptance cycle wins over in_valid
    issue(OP_ADD, 32'd1, 32'd1, 1'b0, 0, 2'd0, 2'd0, 1'b1);
    check("flush_acc_valid", out_valid, 0);
    issue(OP_MULT, 32'd3, 32'd3, 1'b0, 0, 2'd0, 2'd0, 1'b1);
    check("flush_acc_busy", busy, 0);
    check("flush_acc_mvalid", out_valid, 0);

`ifdef EX_MULDIV_DIV_EN
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 0, 2'd0, 2'd0, 1'b0);
    check("div_busy", busy, 1);
    check("div_wr", out_wr, 0);
    wait_idle(n);
    check("div_cycles", n, 32);
    alu_chk("div_lo", OP_MFLO, 0, 0, 1'b0, 0, 2'd0, 2'd0, 32'hFFFFFFFD);
    alu_chk("div_hi", OP_MFHI, 0, 0, 1'b0, 0, 2'd0, 2'd0, 32'hFFFFFFFF);
    issue(OP_DIVU, 32'd9, 32'd0, 1'b0, 0, 2'd0, 2'd0, 1'b0);
    wait_idle(n);
    check("divz_cycles", n, 32);
    alu_chk("divz_lo", OP_MFLO, 0, 0, 1'b0, 0, 2'd0, 2'd0, 32'hFFFFFFFF);
    alu_chk("divz_hi", OP_MFHI, 0, 0, 1'b0, 0, 2'd0, 2'd0, 32'd9);
`else
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 0, 2'd0, 2'd0, 1'b0);
    check("nodiv_valid", out_valid, 1);
    check("nodiv_wr",    out_wr, 0);
    check("nodiv_busy",  busy, 0);
    check("nodiv_res",   result, 0);
    alu_chk("nodiv_lo", OP_MFLO, 0, 0, 1'b0, 0, 2'd0, 2'd0, 32'd4);
    alu_chk("nodiv_hi", OP_MFHI, 0, 0, 1'b0, 0, 2'd0, 2'd0, 32'd2);
`endif

    // Reset at RUN cycle 5
    issue(OP_MULT, 32'd3, 32'd5, 1'b0, 0, 2'd0, 2'd0, 1'b0);
    check("pre_rst_store", store_data, 5);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy",  busy, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_wr",    out_wr, 0);
    check("mid_rst_res",   result, 0);
    check("mid_rst_store", store_data, 0);
    check("mid_rst_state", dut.u_seq.state_reg, ST_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    alu_chk("post_rst_hi", OP_MFHI, 0, 0, 1'b0, 0, 2'd0, 2'd0, 32'd0);
    alu_chk("post_rst_lo", OP_MFLO, 0, 0, 1'b0, 0, 2'd0, 2'd0, 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_stage.md
EX_MULDIV_STAGE -- requirements
Module: ex_muldiv_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32: datapath width; legal values are even and at least 8.
REQ-002 SHALL have parameter CNT_W, default $clog2(DATA_W)+1: width of the iteration counter.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have ports in_valid, input, 1, and in_ready, output, 1: issue handshake; an op is accepted on a cycle where both are 1.
REQ-006 SHALL have port flush, input, 1: kills the in-flight op.
REQ-007 SHALL have port op, input, 4: ex_pkg operation code.
REQ-008 SHALL have ports rs_val and rt_val, input, DATA_W: register-file operands.
REQ-009 SHALL have ports imm, input, DATA_W, and use_imm, input, 1: immediate operand and its select.
REQ-010 SHALL have ports fwd_a and fwd_b, input, 2: forward selects; 0 = regfile, 1 = fwd_exmem, 2 = fwd_wb, 3 = regfile.
REQ-011 SHALL have ports fwd_exmem and fwd_wb, input, DATA_W: forwarded values.
REQ-012 SHALL have ports out_valid, output, 1, and out_wr, output, 1: result-valid pulse and register-write enable.
REQ-013 SHALL have ports result, output, DATA_W, and store_data, output, DATA_W: registered result and forwarded rt.
REQ-014 SHALL have ports busy, output, 1, and stall, output, 1: mul/div unit running, and hazard-unit stall (stall = in_valid & ~in_ready).

Function
REQ-015 SHALL form operand A from fwd_a, and operand B from fwd_b unless use_imm=1, in which case B = imm; store_data SHALL always be the fwd_b-selected rt value.
REQ-016 SHALL implement single-cycle ALU ops AND, OR, ADD, SUB, SLT (signed), XOR, NOR, SLL (shift B by A[4:0] mod DATA_W), with results wrapping modulo 2^DATA_W.
REQ-017 SHALL register result, store_data and out_wr one cycle after acceptance and pulse out_valid=1 for exactly one cycle.
REQ-018 SHALL, on acceptance of MULT, MULTU, DIV or DIVU, latch the operands, raise busy the next cycle, and pulse out_valid with out_wr=0 and result=0.
REQ-019 SHALL iterate the radix-2 sequential unit exactly DATA_W cycles, write HI/LO at the end of the last busy cycle, and drop busy in the following cycle.
REQ-020 SHALL hold in_ready=0 while busy; otherwise in_ready=1.
REQ-021 SHALL produce, for MULT/MULTU, the 2*DATA_W-bit product as {HI,LO}, signed or unsigned respectively.
REQ-022 SHALL produce, for DIV/DIVU, LO = quotient and HI = remainder, truncated toward zero, with the remainder taking the sign of the dividend.
REQ-023 SHALL, on divide by zero, set LO to all ones and HI to the dividend, without flagging an error.
REQ-024 SHALL return HI for MFHI and LO for MFLO as single-cycle ops with out_wr=1.
REQ-025 SHALL implement a state machine IDLE -> RUN (on mul/div accept) -> DONE (counter = DATA_W) -> IDLE.
REQ-026 SHALL, on flush in RUN, return to IDLE the next cycle and leave HI/LO unchanged.
REQ-027 SHALL, on flush in the acceptance cycle, suppress that op's out_valid.
REQ-028 SHALL give flush priority over a simultaneous in_valid.

Reset
REQ-029 SHALL, while rst_n=0, asynchronously force result, store_data, HI and LO to 0; out_valid, out_wr and busy to 0; the counter to 0; and the state to IDLE.
REQ-030 SHALL abandon any op in flight on reset mid-operation, without writing HI/LO.

Configuration
REQ-031 SHALL compile in DIV/DIVU support when macro EX_MULDIV_DIV_EN is defined.
REQ-032 SHALL, when EX_MULDIV_DIV_EN is undefined, complete DIV/DIVU in one cycle with out_wr=0, leave HI/LO and busy unchanged, and omit the divider logic.

Structure
REQ-033 SHALL place the op-code enum, forward-select constants and the state encoding in shared package ex_pkg.
REQ-034 SHALL implement the iterative multiplier/divider and HI/LO as sub-module ex_muldiv_seq; operand muxing and the ALU stay in the top module.

Verification
REQ-035 SHALL cover: ADD, rs=5, rt=7, fwd_a=1, fwd_exmem=100 -> result 107 one cycle later, out_wr=1.
REQ-036 SHALL cover: MULT 0xFFFFFFFF x 2 -> busy for 32 cycles, then MFHI=0xFFFFFFFF and MFLO=0xFFFFFFFE.
REQ-037 SHALL cover: DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 9 / 0 -> LO=0xFFFFFFFF, HI=9.
REQ-038 SHALL cover: MFLO issued while busy -> stall=1 until busy drops, then returns the new LO.
REQ-039 SHALL cover: flush at RUN cycle 10 of a MULTU -> HI/LO keep their old values and in_ready=1 two cycles later.
REQ-040 SHALL cover: rst_n low at RUN cycle 5 -> all outputs 0 immediately and the state is IDLE.
